clk_en_lock_seq: RTL

//   Synthesizable, parametrised successor to the sim-only clock-wizard stand-in.

---
 rtl/clk_en_lock_seq.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/clk_en_lock_seq.sv
// clk_en_lock_seq: qualifies an upstream lock, releases per-channel resets in
// staggered order, then generates one divided clock-enable strobe per channel.
// A lock loss after qualification re-sequences every channel and is counted.
module clk_en_lock_seq #(
    parameter int NUM_CH      = 4,
    parameter int DIV_W       = 8,
    parameter int LOCK_CYCLES = 5,
    parameter int STAGGER     = 2,
    parameter int CNT_W       = 16
) (
    input  logic                    clk_in1,
    input  logic                    reset,
    input  logic                    src_locked_i,
    input  logic [NUM_CH*DIV_W-1:0] div_i,
    output logic                    locked,
    output logic [NUM_CH-1:0]       ch_rst,
    output logic [NUM_CH-1:0]       ch_en,
    output logic [7:0]              unlock_count
);

    typedef enum logic [1:0] {
        WAIT_LOCK,
        RELEASE,
        RUN
    } state_t;

    // Qualify count that completes the lock, and the stagger count at which the
    // last channel leaves reset.
    localparam logic [CNT_W-1:0] QUAL_LAST = CNT_W'(LOCK_CYCLES - 1);
    localparam logic [CNT_W-1:0] STAG_LAST = CNT_W'(STAGGER * NUM_CH);

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  qual_q, qual_d;
    logic [CNT_W-1:0]  stag_q, stag_d, stag_inc;
    logic              locked_q, locked_d;
    logic [NUM_CH-1:0] ch_rst_q, ch_rst_d;
    logic [7:0]        unl_q, unl_d;
    logic              lock_evt;   // qualification completes on this edge
    logic              kill;       // lock lost after qualification

    // Sequencer next-state: lock qualification, staggered release, loss handling.
    always_comb begin
        state_d  = state_q;
        qual_d   = qual_q;
        stag_d   = stag_q;
        stag_inc = stag_q + CNT_W'(1);
        locked_d = locked_q;
        ch_rst_d = ch_rst_q;
        unl_d    = unl_q;
        lock_evt = 1'b0;
        kill     = 1'b0;
        case (state_q)
            WAIT_LOCK: begin
                if (src_locked_i) begin
                    if (qual_q == QUAL_LAST) begin
                        lock_evt = 1'b1;
                        locked_d = 1'b1;
                        qual_d   = '0;
                        stag_d   = '0;
                        state_d  = RELEASE;
                    end else begin
                        qual_d = qual_q + CNT_W'(1);
                    end
                end else begin
                    // A drop before qualification just restarts the run.
                    qual_d = '0;
                end
            end
            RELEASE: begin
                if (!src_locked_i) begin
                    kill = 1'b1;
                end else begin
                    stag_d = stag_inc;
                    for (int k = 0; k < NUM_CH; k++) begin
                        if (stag_inc == CNT_W'(STAGGER * (k + 1))) begin
                            ch_rst_d[k] = 1'b0;
                        end
                    end
                    if (stag_inc == STAG_LAST) begin
                        stag_d  = '0;
                        state_d = RUN;
                    end
                end
            end
            RUN: begin
                if (!src_locked_i) begin
                    kill = 1'b1;
                end
            end
            default: begin
                state_d = WAIT_LOCK;
            end
        endcase
        // Lock loss overrides any release due on the same edge.
        if (kill) begin
            locked_d = 1'b0;
            ch_rst_d = '1;
            qual_d   = '0;
            stag_d   = '0;
            state_d  = WAIT_LOCK;
            if (unl_q != 8'hFF) begin
                unl_d = unl_q + 8'd1;
            end
        end
    end

    // Sequencer state registers.
    always_ff @(posedge clk_in1) begin
        if (reset) begin
            state_q  <= WAIT_LOCK;
            qual_q   <= '0;
            stag_q   <= '0;
            locked_q <= 1'b0;
            ch_rst_q <= '1;
            unl_q    <= '0;
        end else begin
            state_q  <= state_d;
            qual_q   <= qual_d;
            stag_q   <= stag_d;
            locked_q <= locked_d;
            ch_rst_q <= ch_rst_d;
            unl_q    <= unl_d;
        end
    end

    assign locked       = locked_q;
    assign ch_rst       = ch_rst_q;
    assign unlock_count = unl_q;

    // One divider per channel; the divide ratio is frozen at qualification.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
        logic [DIV_W-1:0] div_q, div_d;
        logic [DIV_W-1:0] cnt_q, cnt_d;
        logic [DIV_W-1:0] cnt_last;
        logic             en_q, en_d;

        // Divider next-state: count 0..D-1 while out of reset, strobe on D-1.
        always_comb begin
            div_d    = lock_evt ? div_i[gi*DIV_W +: DIV_W] : div_q;
            // A ratio of 0 behaves as 1, so both give a terminal count of 0.
            cnt_last = (div_q == '0) ? '0 : div_q - DIV_W'(1);
            cnt_d    = '0;
            en_d     = 1'b0;
            if (!kill && !ch_rst_q[gi]) begin
                en_d  = (cnt_q == cnt_last);
                cnt_d = (cnt_q == cnt_last) ? '0 : cnt_q + DIV_W'(1);
            end
        end

        // Divider registers; the strobe is registered so it lands D cycles after release.
        always_ff @(posedge clk_in1) begin
            if (reset) begin
                div_q <= '0;
                cnt_q <= '0;
                en_q  <= 1'b0;
            end else begin
                div_q <= div_d;
                cnt_q <= cnt_d;
                en_q  <= en_d;
            end
        end

        assign ch_en[gi] = en_q;
    end

endmodule
